// File: rtl/bht_upd_sched_if.sv
// Resolve-side bus of the BHT update scheduler.
// Carries both execute-pipe requests, control and the drain port.
interface bht_upd_sched_if #(
   parameter int addr_width = 32,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  REQ0_VALID;
   logic [addr_width-1:0] REQ0_PC;
   logic                  REQ0_TAKE;
   logic                  REQ0_RDY;
   logic                  REQ1_VALID;
   logic [addr_width-1:0] REQ1_PC;
   logic                  REQ1_TAKE;
   logic                  REQ1_RDY;
   logic                  FLUSH;
   logic                  BHT_STALL;
   logic [addr_width-1:0] UPD_PC;
   logic                  UPD_TAKE;
   logic                  UPD_WE;
   logic [CW-1:0]         OCC;

   modport master (
      output REQ0_VALID, REQ0_PC, REQ0_TAKE,
      output REQ1_VALID, REQ1_PC, REQ1_TAKE,
      output FLUSH, BHT_STALL,
      input  REQ0_RDY, REQ1_RDY,
      input  UPD_PC, UPD_TAKE, UPD_WE, OCC
   );

   modport slave (
      input  REQ0_VALID, REQ0_PC, REQ0_TAKE,
      input  REQ1_VALID, REQ1_PC, REQ1_TAKE,
      input  FLUSH, BHT_STALL,
      output REQ0_RDY, REQ1_RDY,
      output UPD_PC, UPD_TAKE, UPD_WE, OCC
   );
endinterface

// File: rtl/bht_upd_sched.sv
// Two-pipe BHT update scheduler: RR accept into a FIFO, one drain/cycle.
// Optional same-cycle idle bypass: define BHT_UPD_BYPASS_EN.
module bht_upd_sched #(
   parameter int addr_width = 32,
   parameter int DEPTH      = 4
) (
   input logic            CLK,
   input logic            RST,
   bht_upd_sched_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [addr_width-1:0] pc;
      logic                  take;
   } ent_t;

   ent_t          mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] occ_q, occ_d;
   logic          rr_q, rr_d;

   logic [CW-1:0] free;
   logic          v0, v1, rdy0, rdy1;
   logic          acc0, acc1, both, any, fsel;
   logic          byp, we, deq;
   logic          wr0_en, wr1_en;
   ent_t          e0, e1, ent_a, ent_b;
   ent_t          wr0_ent, head_ent;

   assign v0 = bus.REQ0_VALID;
   assign v1 = bus.REQ1_VALID;
   assign e0 = '{pc: bus.REQ0_PC, take: bus.REQ0_TAKE};
   assign e1 = '{pc: bus.REQ1_PC, take: bus.REQ1_TAKE};

   // Accept decision from registered occupancy; loser on last slot waits.
   always_comb begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      free = CW'(DEPTH) - occ_q;
      if (!RST && !bus.FLUSH) begin
         if (free >= CW'(2)) begin
            rdy0 = 1'b1;
            rdy1 = 1'b1;
         end else if (free == CW'(1)) begin
            rdy0 = !(v0 && v1) || !rr_q;
            rdy1 = !(v0 && v1) || rr_q;
         end
      end
   end

   assign acc0  = v0 && rdy0;
   assign acc1  = v1 && rdy1;
   assign both  = acc0 && acc1;
   assign any   = acc0 || acc1;
   assign fsel  = both ? rr_q : acc1;
   assign ent_a = fsel ? e1 : e0;
   assign ent_b = fsel ? e0 : e1;

`ifdef BHT_UPD_BYPASS_EN
   assign byp = (occ_q == '0) && !bus.BHT_STALL
             && !bus.FLUSH && any;
`else
   assign byp = 1'b0;
`endif

   assign we = !RST && !bus.FLUSH && !bus.BHT_STALL
            && ((occ_q != '0) || byp);
   assign deq = we && !byp;

   assign wr0_en  = byp ? both : any;
   assign wr0_ent = byp ? ent_b : ent_a;
   assign wr1_en  = !byp && both;

   assign head_ent = mem_q[head_q];

   // Next-state for pointers, occupancy and round-robin favour.
   always_comb begin
      occ_d  = occ_q + CW'(acc0) + CW'(acc1) - CW'(we);
      head_d = head_q + PW'(deq);
      tail_d = tail_q + PW'(wr0_en) + PW'(wr1_en);
      rr_d   = rr_q;
      if (v0 && v1 && (acc0 ^ acc1))
         rr_d = acc0;
   end

   // Control state; reset beats flush, flush keeps the rr favour.
   always_ff @(posedge CLK) begin
      if (RST) begin
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         rr_q   <= 1'b0;
      end else if (bus.FLUSH) begin
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         rr_q   <= rr_d;
      end
   end

   // Storage writes; winner at tail, second request right behind it.
   always_ff @(posedge CLK) begin
      if (wr0_en)
         mem_q[tail_q] <= wr0_ent;
      if (wr1_en)
         mem_q[tail_q + PW'(1)] <= ent_b;
   end

   assign bus.REQ0_RDY = rdy0;
   assign bus.REQ1_RDY = rdy1;
   assign bus.UPD_WE   = we;
   assign bus.UPD_PC   = byp ? ent_a.pc : head_ent.pc;
   assign bus.UPD_TAKE = byp ? ent_a.take : head_ent.take;
   assign bus.OCC      = occ_q;

`ifndef SYNTHESIS
   // Occupancy can never exceed the buffer size.
   always_ff @(posedge CLK) begin
      assert (occ_q <= CW'(DEPTH));
   end
`endif
endmodule

// File: tb/tb_bht_upd_sched.sv
// Randomized scoreboard bench for bht_upd_sched.
// Expected updates are queued at accept; a monitor pops on UPD_WE.
module tb_bht_upd_sched;
   localparam int AW = 32;
   localparam int D  = 4;

   typedef struct {
      logic [AW-1:0] pc;
      logic          take;
   } upd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bht_upd_sched_if #(.addr_width(AW), .DEPTH(D)) bus ();

   bht_upd_sched #(.addr_width(AW), .DEPTH(D)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   upd_t sb[$];
   int   mocc = 0;
   bit   rr   = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit v0,
                      input bit v1, input bit st,
                      input bit f);
      int   fr;
      bit   e0, e1, a0, a1, byp, ewe;
      upd_t u0, u1;
      @(negedge clk);
      u0.pc   = $urandom;
      u0.take = 1'($urandom_range(1));
      u1.pc   = $urandom;
      u1.take = 1'($urandom_range(1));
      rst            = r;
      bus.REQ0_VALID = v0;
      bus.REQ0_PC    = u0.pc;
      bus.REQ0_TAKE  = u0.take;
      bus.REQ1_VALID = v1;
      bus.REQ1_PC    = u1.pc;
      bus.REQ1_TAKE  = u1.take;
      bus.BHT_STALL  = st;
      bus.FLUSH      = f;
      #1;
      fr = D - mocc;
      if (r || f) begin
         e0 = 0; e1 = 0;
      end else if (fr >= 2) begin
         e0 = 1; e1 = 1;
      end else if (fr == 1) begin
         e0 = v1 ? !rr : 1'b1;
         e1 = v0 ? rr : 1'b1;
      end else begin
         e0 = 0; e1 = 0;
      end
      if (v0 || r || f) chk("rdy0", 32'(bus.REQ0_RDY), 32'(e0));
      if (v1 || r || f) chk("rdy1", 32'(bus.REQ1_RDY), 32'(e1));
      a0 = v0 && e0;
      a1 = v1 && e1;
`ifdef BHT_UPD_BYPASS_EN
      byp = (mocc == 0) && !st && !f && !r && (a0 || a1);
`else
      byp = 1'b0;
`endif
      ewe = !r && !f && !st && ((mocc != 0) || byp);
      chk("occ", 32'(bus.OCC), 32'(mocc));
      if (!r) chk("upd_we", 32'(bus.UPD_WE), 32'(ewe));
      if (r) begin
         sb.delete();
         mocc = 0;
         rr   = 1'b0;
      end else if (f) begin
         sb.delete();
         mocc = 0;
      end else begin
         if (a0 && a1) begin
            sb.push_back(rr ? u1 : u0);
            sb.push_back(rr ? u0 : u1);
         end else if (a0) begin
            sb.push_back(u0);
         end else if (a1) begin
            sb.push_back(u1);
         end
         mocc = mocc + int'(a0) + int'(a1) - int'(ewe);
         if (v0 && v1 && (a0 != a1)) rr = a0;
      end
   endtask

   initial begin : monitor
      upd_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.UPD_WE === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_underflow: got UPD_WE=1 want no update at %0t",
                        $time);
            end else begin
               e = sb.pop_front();
               chk("upd_pc", bus.UPD_PC, e.pc);
               chk("upd_take", 32'(bus.UPD_TAKE), 32'(e.take));
            end
         end
      end
   end

   initial begin : stim
      int sp;
      bus.REQ0_VALID = 0;
      bus.REQ0_PC    = '0;
      bus.REQ0_TAKE  = 0;
      bus.REQ1_VALID = 0;
      bus.REQ1_PC    = '0;
      bus.REQ1_TAKE  = 0;
      bus.BHT_STALL  = 0;
      bus.FLUSH      = 0;
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int c = 0; c < 4000; c++) begin
         sp = ((c / 40) % 2 == 1) ? 70 : 15;
         cyc($urandom_range(99) < 1,
             $urandom_range(99) < 60,
             $urandom_range(99) < 60,
             $urandom_range(99) < sp,
             $urandom_range(99) < 3);
      end
      for (int i = 0; i < D + 3; i++) cyc(0, 0, 0, 0, 0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bht_upd_sched.md
Name: bht_upd_sched

Overview:
Update scheduler for the branch history table's single resolve port (PC_IN_RES/TAKE_IN/WE). Accepts branch resolutions from two execute pipes through valid/ready handshakes and buffers them in a DEPTH-entry FIFO. Arbitrates round-robin when space is short, then drains at most one update per cycle into the history table. Sits between the execute stages and the history table; prediction traffic does not pass through it.

Parameters:
addr_width, 32, width of PC fields
DEPTH, 4, FIFO entries; power of two, >=2
CW, $clog2(DEPTH)+1, width of OCC (localparam, not overridable)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous reset, active-high
REQ0_VALID  input  1  pipe 0 has a resolution
REQ0_PC  input  addr_width  pipe 0 branch PC
REQ0_TAKE  input  1  pipe 0 branch outcome (1 = taken)
REQ0_RDY  output  1  pipe 0 resolution accepted this cycle if VALID
REQ1_VALID  input  1  pipe 1 has a resolution
REQ1_PC  input  addr_width  pipe 1 branch PC
REQ1_TAKE  input  1  pipe 1 branch outcome
REQ1_RDY  output  1  pipe 1 resolution accepted this cycle if VALID
FLUSH  input  1  discard all buffered updates
BHT_STALL  input  1  history table cannot accept updates this cycle
UPD_PC  output  addr_width  to history table PC_IN_RES
UPD_TAKE  output  1  to history table TAKE_IN
UPD_WE  output  1  to history table WE
OCC  output  CW  current FIFO occupancy

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. RST=1 at a posedge clears all state. This includes during a drain or an in-flight accept; no pending update survives reset.
- Reset values: OCC=0, head/tail pointers=0, rr pointer=0 (pipe 0 favoured), UPD_WE=0.
- While RST=1, REQ0_RDY and REQ1_RDY are forced to 0.
- FIFO state: circular buffer of {pc, take}. Pointers are log2(DEPTH) bits and wrap naturally. OCC ranges 0..DEPTH.
- free = DEPTH - OCC, computed from registered OCC. A same-cycle dequeue does not add space.
- Accept rules, evaluated combinationally each cycle:
  - free>=2: both RDY=1; both valid requests are enqueued.
  - free==1, one valid: that requester gets RDY=1.
  - free==1, both valid: only the rr winner gets RDY=1; the loser gets RDY=0.
  - free==0: both RDY=0.
- RDY may depend combinationally on the other pipe's VALID. Requesters must not make VALID depend on RDY.
- Enqueue order when both are accepted: the rr winner is written at tail and the other at tail+1. Ordering between pipes follows rr; per-pipe order is always preserved.
- rr pointer: toggles away from the winner whenever both are valid and only one is accepted. It is unchanged when both are accepted or only one is valid.
- Drain:
  - UPD_WE = (OCC!=0) && !BHT_STALL && !FLUSH.
  - UPD_PC/UPD_TAKE = head entry, combinational from storage.
  - UPD_PC/UPD_TAKE are don't-care when UPD_WE=0.
  - Head advances on each posedge where UPD_WE=1.
- Latency: a request accepted at edge N is visible on UPD_* in cycle N+1 at the earliest.
- Simultaneous enqueue and dequeue: OCC_next = OCC + accepted - (UPD_WE?1:0). A full FIFO draining one entry still shows RDY=0 in that cycle.
- FLUSH:
  - At the posedge, OCC and both pointers go to 0 and the rr pointer is unchanged.
  - In a FLUSH cycle, both RDY=0 and no request is accepted.
  - FLUSH has priority over enqueue and drain. RST has priority over FLUSH.
- BHT_STALL: holds the head entry and UPD_WE=0; enqueue continues normally.
- Overflow/underflow are impossible by construction. Implementation asserts OCC<=DEPTH under simulation.

Optional Feature:
Macro BHT_UPD_BYPASS_EN.
- Defined: when OCC==0, !BHT_STALL and !FLUSH, the selected request bypasses the FIFO.
  - With one valid, it is that request; with both valid, it is the rr winner.
  - It drives UPD_PC/UPD_TAKE/UPD_WE=1 combinationally in the same cycle it is accepted. It is not written into the FIFO.
  - A second simultaneously accepted request is written at tail. The rr pointer still follows the accept rules.
  - Zero-cycle latency when idle.
- Undefined: no bypass path. Every update goes through storage, giving a minimum latency of 1 cycle.

Test Plan:
- Reset then single accept: RST high 2 cycles, REQ0 pc=0x100 take=1 for 1 cycle. -> RDY0=1. Next cycle UPD_WE=1, UPD_PC=0x100, UPD_TAKE=1, OCC=1, then OCC=0. (With bypass: UPD_WE=1 in the accept cycle, OCC stays 0.)
- Dual accept and order: DEPTH=4, rr=0, both valid, pc0=0x10, pc1=0x20, BHT_STALL=1. -> OCC=2. Release stall: UPD_PC 0x10 then 0x20 on consecutive cycles.
- Fill and fairness: BHT_STALL=1, drive both valid continuously. -> OCC 2, 4 (full), both RDY=0. Stall 1 cycle at OCC=3, then both valid: only rr winner gets RDY. The next contended slot goes to the other pipe.
- Full with simultaneous drain: OCC=4, BHT_STALL=0, REQ0 valid. -> RDY0=0 that cycle, OCC=3 next cycle. RDY0=1 the following cycle, OCC returns to 4 only if the stall is reasserted.
- FLUSH priority: OCC=3, FLUSH=1 with REQ0 valid and stall=0. -> RDY0=0, UPD_WE=0, OCC=0 next cycle.
- Reset mid-operation: OCC=2, assert RST together with both valid. -> after the edge OCC=0, UPD_WE=0, RDY=0 while RST high, rr=0.
